// File: rtl/tap_ram_arbiter.sv
// Shares the single-port tap BRAM between host and FIR engine (engine first, host after pMAX_WAIT losses).
// Grants are same-cycle, read data returns 1 cycle after grant; host writes stall while eng_lock is high.
module tap_ram_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_WAIT   = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [pADDR_WIDTH-1:0] host_addr,
  input  logic [pDATA_WIDTH-1:0] host_wdata,
  output logic                   host_gnt,
  output logic                   host_rvalid,
  output logic [pDATA_WIDTH-1:0] host_rdata,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  input  logic                   eng_lock,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [3:0] MAX_WAIT = 4'(pMAX_WAIT);

  logic       host_elig;
  logic       eng_elig;
  logic       host_win;
  logic [3:0] starve_cnt;
  logic       hr_pend;
  logic       er_pend;

  // Grants are gated by reset so every output is quiet while reset is held.
  always_comb begin
    host_elig = host_req & ~(host_we & eng_lock);
    eng_elig  = eng_req;
    host_win  = host_elig & (~eng_elig | (starve_cnt == MAX_WAIT));
    host_gnt  = axis_rst_n & host_win;
    eng_gnt   = axis_rst_n & eng_elig & ~host_win;

    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (host_gnt) begin
      tap_EN = 1'b1;
      tap_WE = host_we ? 4'hf : 4'h0;
      tap_A  = host_addr;
      tap_Di = host_wdata;
    end else if (eng_gnt) begin
      tap_EN = 1'b1;
      tap_A  = eng_addr;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      starve_cnt <= 4'd0;
      hr_pend    <= 1'b0;
      er_pend    <= 1'b0;
    end else begin
      hr_pend <= host_gnt & ~host_we;
      er_pend <= eng_gnt;
      // A write parked behind eng_lock is not eligible, so it never accrues wait credit.
      if (host_gnt || !host_elig) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt < MAX_WAIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    host_rvalid = hr_pend;
    host_rdata  = hr_pend ? tap_Do : '0;
    eng_rvalid  = er_pend;
    eng_rdata   = er_pend ? tap_Do : '0;
  end

endmodule

// File: tb/tb_tap_ram_arbiter.sv
// Scoreboard bench for tap_ram_arbiter: stimulus pushes expected bus/read-return records, a monitor pops them.
// Reference model tracks consecutive host losses and a word memory; a behavioural BRAM answers tap_* pins.
module tb_tap_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          eng_req, eng_gnt, eng_rvalid, eng_lock;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_rdata;
  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [DW-1:0] tap_Di;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Do = '0;

  tap_ram_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pMAX_WAIT(MW)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata), .eng_lock(eng_lock),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Behavioural single-port BRAM, read-first, one cycle read latency.
  logic [DW-1:0] bram [int];
  always @(posedge axis_clk) begin
    logic [DW-1:0] rd;
    if (tap_EN) begin
      rd = bram.exists(int'(tap_A)) ? bram[int'(tap_A)] : init_word(tap_A);
      if (tap_WE == 4'hf) bram[int'(tap_A)] = tap_Di;
      tap_Do <= rd;
    end
  end

  typedef struct packed {
    logic          hg;
    logic          eg;
    logic          en;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
  } bus_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  bus_t          bq[$];
  rd_t           hq[$];
  rd_t           eq[$];
  logic [DW-1:0] ref_mem [int];
  int            losses = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  // Drive one cycle of inputs and record what the arbiter must do with them.
  task automatic step(input logic rst, input logic hr, input logic hw, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd, input logic er, input logic [AW-1:0] ea,
                      input logic lk, output logic hg, output logic eg);
    bus_t e;
    logic host_ok;
    @(posedge axis_clk);
    #1;
    axis_rst_n = rst; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    eng_req = er; eng_addr = ea; eng_lock = lk;

    host_ok = rst && hr && !(hw && lk);
    hg = host_ok && (!(rst && er) || losses >= MW);
    eg = rst && er && !hg;
    e = '0;
    e.hg = hg;
    e.eg = eg;
    if (hg) begin
      e.en = 1'b1; e.we = hw ? 4'hf : 4'h0; e.a = ha; e.di = hd;
      if (hw) ref_mem[int'(ha)] = hd;
      else hq.push_back('{data: ref_rd(ha), due: cyc + 1});
    end else if (eg) begin
      e.en = 1'b1; e.a = ea;
      eq.push_back('{data: ref_rd(ea), due: cyc + 1});
    end
    bq.push_back(e);

    if (!rst) begin
      losses = 0;
      hq.delete();
      eq.delete();
    end else if (hg || !host_ok) losses = 0;
    else losses++;
  endtask

  initial begin
    forever begin
      bus_t exp_b, act_b;
      rd_t  r;
      logic exp_v;
      @(negedge axis_clk);
      if (bq.size() > 0) begin
        exp_b = bq.pop_front();
        act_b.hg = host_gnt; act_b.eg = eng_gnt; act_b.en = tap_EN;
        act_b.we = tap_WE;   act_b.a = tap_A;    act_b.di = tap_Di;
        check("grant_and_bus", 64'(act_b), 64'(exp_b));
      end
      exp_v = (hq.size() > 0 && hq[0].due == cyc);
      check("host_rvalid", host_rvalid, exp_v);
      if (exp_v) begin
        r = hq.pop_front();
        check("host_rdata", host_rdata, r.data);
      end else check("host_rdata_idle", host_rdata, '0);
      exp_v = (eq.size() > 0 && eq[0].due == cyc);
      check("eng_rvalid", eng_rvalid, exp_v);
      if (exp_v) begin
        r = eq.pop_front();
        check("eng_rdata", eng_rdata, r.data);
      end else check("eng_rdata_idle", eng_rdata, '0);
    end
  end

  initial begin
    logic hg, eg, got;
    logic hp, hwp, ep, lk, rr;
    logic [AW-1:0] ha, ea;
    logic [DW-1:0] hd;

    axis_rst_n = 1'b1; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    eng_req = 0; eng_addr = '0; eng_lock = 0;
    #1 axis_rst_n = 1'b0;

    // Reset held with requests present: everything quiet.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 12'h40, 32'h5, 1, 12'h44, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);

    // Uncontended writes, then engine read back.
    step(1, 1, 1, 12'h40, 32'hA5, 0, '0, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);
    step(1, 1, 1, 12'h44, 32'h1234, 0, '0, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);
    step(1, 0, 0, '0, '0, 1, 12'h44, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);

    // Engine streaming while a host read at 0x48 waits its turn.
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, !got, 0, 12'h48, '0, 1, 12'h40, 0, hg, eg);
      if (hg) got = 1;
    end

    // Host write parked behind the lock, engine toggling; released with engine idle.
    for (int i = 0; i < 20; i++) step(1, 1, 1, 12'h50, 32'hBEEF, i[0], 12'h44, 1, hg, eg);
    step(1, 1, 1, 12'h50, 32'hBEEF, 0, '0, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);

    // Lock held with engine busy: on release the host starts from zero wait credit.
    for (int i = 0; i < 20; i++) step(1, 1, 1, 12'h54, 32'hCAFE, 1, 12'h50, 1, hg, eg);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, !got, 1, 12'h54, 32'hCAFE, 1, 12'h54, 0, hg, eg);
      if (hg) got = 1;
    end

    // Host read under lock goes straight through.
    step(1, 1, 0, 12'h4C, '0, 0, '0, 1, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 1, hg, eg);

    // Reset lands the cycle after a host read grant: the return is dropped.
    step(1, 1, 0, 12'h50, '0, 0, '0, 0, hg, eg);
    step(0, 0, 0, '0, '0, 0, '0, 0, hg, eg);
    step(0, 0, 0, '0, '0, 0, '0, 0, hg, eg);
    step(1, 0, 0, '0, '0, 1, 12'h44, 0, hg, eg);
    step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);

    // Random traffic honouring the hold-until-grant rule, with cancels, lock bursts and resets.
    hp = 0; hwp = 0; ep = 0; lk = 0; ha = '0; ea = '0; hd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hp && $urandom_range(0, 2) == 0) begin
        hp = 1; hwp = 1'($urandom_range(0, 1));
        ha = AW'($urandom_range(0, 31) * 4); hd = $urandom;
      end else if (hp && $urandom_range(0, 19) == 0) hp = 0;
      if (!ep && $urandom_range(0, 3) != 0) begin
        ep = 1; ea = AW'($urandom_range(0, 31) * 4);
      end else if (ep && $urandom_range(0, 29) == 0) ep = 0;
      if ($urandom_range(0, 15) == 0) lk = !lk;
      rr = ($urandom_range(0, 499) != 0);
      step(rr, hp, hwp, ha, hd, ep, ea, lk, hg, eg);
      if (hg) hp = 0;
      if (eg) ep = 0;
    end

    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 0, '0, 0, hg, eg);
    @(negedge axis_clk);
    @(negedge axis_clk);
    check("scoreboard_drained", 64'(bq.size() + hq.size() + eq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_ram_arbiter.md
# tap_ram_arbiter

Shares the single-port tap-coefficient BRAM between two requesters: the AXI-Lite host path, which writes and reads coefficients, and the FIR compute engine, which reads coefficients during the MAC sweep. The engine has priority. A bounded-wait counter guarantees host progress. While the engine holds the coefficient lock, host writes are blocked so that coefficients cannot change mid-sweep. The block sits between the AXI-Lite decoder / FIR engine and the tap BRAM pins.

## Interface
- pADDR_WIDTH, 12, BRAM byte address width
- pDATA_WIDTH, 32, data width
- pMAX_WAIT, 4, consecutive lost arbitrations after which the host wins; range 1..15

- axis_clk  in  1  clock, rising edge
- axis_rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host access request; held until host_gnt
- host_we  in  1  1 = write, 0 = read; stable while host_req
- host_addr  in  pADDR_WIDTH  host address; stable while host_req
- host_wdata  in  pDATA_WIDTH  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  pDATA_WIDTH  host read data
- eng_req  in  1  engine read request
- eng_addr  in  pADDR_WIDTH  engine read address
- eng_gnt  out  1  engine read performed this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  pDATA_WIDTH  engine read data
- eng_lock  in  1  engine sweep active; blocks host writes
- tap_WE  out  4  BRAM byte write enables
- tap_EN  out  1  BRAM enable
- tap_Di  out  pDATA_WIDTH  BRAM write data
- tap_A  out  pADDR_WIDTH  BRAM address
- tap_Do  in  pDATA_WIDTH  BRAM read data, one cycle after EN

## Operation
- **Eligibility:**
  - host_elig = host_req & ~(host_we & eng_lock).
  - eng_elig = eng_req.
- **Arbitration (combinational, same cycle):**
  - If host_elig and (~eng_elig or starve_cnt == pMAX_WAIT): host_gnt = 1.
  - Else if eng_elig: eng_gnt = 1.
  - At most one grant per cycle.
- **BRAM drive:**
  - Host grant: tap_EN = 1, tap_A = host_addr, tap_Di = host_wdata, tap_WE = host_we ? 4'hf : 4'h0.
  - Engine grant: tap_EN = 1, tap_A = eng_addr, tap_WE = 0, tap_Di = 0.
  - No grant: tap_EN = 0, tap_WE = 0, tap_A = 0, tap_Di = 0.
- **starve_cnt (4-bit register):**
  - Cleared on host_gnt or when ~host_elig.
  - Otherwise, when host_elig and ~host_gnt, increments and saturates at pMAX_WAIT.
- **Read return:**
  - Registered tags: hr_pend <= host_gnt & ~host_we; er_pend <= eng_gnt.
  - host_rvalid = hr_pend; host_rdata = hr_pend ? tap_Do : 0.
  - eng_rvalid = er_pend; eng_rdata = er_pend ? tap_Do : 0.
  - Both pend bits are never set in the same cycle.
- Host write completion is signalled by host_gnt alone; there is no write response.
- A blocked host write (eng_lock = 1) waits indefinitely without counting. It is granted in the first cycle after eng_lock falls, subject to normal arbitration.
- Host reads are never blocked by eng_lock.

## Timing
- **Reset values:** all outputs 0; starve_cnt = 0; hr_pend = er_pend = 0.
- Reset asserted mid-operation drops any pending read return; no rvalid follows.
- Grant latency is 0 cycles when uncontended. Read data latency is exactly 1 cycle after the grant.
- Engine issuing eng_req every cycle gets back-to-back grants, except exactly 1 of every pMAX_WAIT+1 cycles while the host is eligible.
- **Simultaneous requests:**
  - starve_cnt < pMAX_WAIT: the engine wins.
  - starve_cnt == pMAX_WAIT: the host wins, and the counter clears the next cycle.
- A requester must hold req/addr/we/wdata stable until its gnt. Dropping req before gnt is allowed and cancels the request.
- A write grant must never produce rvalid.

## Test plan
- **Uncontended host write:** host_req = 1, we = 1, addr = 0x40, wdata = 0xA5 -> same cycle host_gnt = 1, tap_EN = 1, tap_WE = 4'hf, tap_A = 0x40, tap_Di = 0xA5; next cycle host_rvalid = 0.
- **Engine read:** eng_req = 1, addr = 0x44, BRAM returns 0x1234 -> eng_gnt in cycle N; eng_rvalid = 1 and eng_rdata = 0x1234 in cycle N+1.
- **Starvation guard:** eng_req held high, host read at 0x48 held, pMAX_WAIT = 4 -> engine granted for 4 cycles, host granted in the 5th, host_rvalid the cycle after, engine resumes.
- **Lock:** eng_lock = 1 with a host write pending for 20 cycles -> no host_gnt and starve_cnt = 0 throughout. Drop eng_lock with eng_req = 0 -> host_gnt that cycle.
- **Lock with host read:** eng_lock = 1, eng_req = 0, host read at 0x4C -> granted immediately.
- **Reset mid-read:** assert axis_rst_n = 0 in the cycle after a host read grant -> host_rvalid = 0 and all outputs 0; after release, a fresh engine request is granted with 0 latency.
